sino_pipe: RTL and testbench

- Parametrised, fully pipelined sine/cosine generator for the Box-Muller AWGN datapath.
- Takes a uniform phase word u (fraction of a full turn) and returns cos(2πu) and sin(2πu), each scaled by an optional per-sample radius r.
- The radius r is sqrt(-2 ln u0), produced upstream.
- Uses a quarter-wave LUT with linear interpolation and a valid/ready handshake with full backpressure.

---
 rtl/sino_pipe.sv | 171 +++++++++++++++++
 tb/tb_sino_pipe.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sino_pipe.sv
// sino_pipe: cos/sin of a phase word via a quarter-wave LUT with linear interpolation, optional radius scale.
// Latency 4 cycles, 1 sample/cycle; an output stall freezes all four stages and bubbles are kept.
module sino_pipe #(
    parameter int U_W    = 16,
    parameter int LUT_AW = 8,
    parameter int OUT_W  = 18,
    parameter int F_W    = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [U_W-1:0]              u1,
    input  logic [F_W-1:0]              r,
    input  logic                        raw,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_W+F_W-1:0] g0,
    output logic signed [OUT_W+F_W-1:0] g1
);
    localparam int G_W = OUT_W + F_W;
    localparam int XW  = U_W - 1;
    localparam int FR  = U_W - 2 - LUT_AW;
    localparam int KW  = LUT_AW + 1;
    localparam int NL  = 2 ** LUT_AW;
    localparam int PRW = OUT_W + FR + 2;
    localparam logic [XW-1:0] M_X = XW'(1) << (U_W - 2);

    typedef struct packed {
        logic           neg_s;
        logic           neg_c;
        logic           raw;
        logic [F_W-1:0] r;
    } side_t;

    // Table entries come from a Taylor series in 64-bit-fraction fixed point, so elaboration needs no real math.
    function automatic logic [OUT_W-1:0] lut_val(input int unsigned k);
        logic [191:0] x, x2, term, acc;
        x    = (192'h1921FB54442D1846A * 192'(k)) >> LUT_AW;
        x2   = (x * x) >> 64;
        term = x;
        acc  = x;
        for (int n = 1; n < 16; n++) begin
            term = ((term * x2) >> 64) / 192'((2 * n) * (2 * n + 1));
            if (n % 2 == 1) acc = acc - term;
            else            acc = acc + term;
        end
        acc = ((acc << (OUT_W - 2)) + (192'(1) << 63)) >> 64;
        return OUT_W'(acc);
    endfunction

    function automatic logic [OUT_W-1:0] interp(input logic [OUT_W-1:0] t0,
                                                input logic [OUT_W-1:0] t1,
                                                input logic [FR-1:0]    f);
        logic signed [PRW-1:0] d;
        logic signed [PRW-1:0] prod;
        d    = $signed(PRW'(t1)) - $signed(PRW'(t0));
        prod = d * $signed(PRW'(f));
        return OUT_W'($signed(PRW'(t0)) + (prod >>> FR));
    endfunction

    function automatic logic [G_W-1:0] sign_scale(input logic [OUT_W-1:0] s,
                                                  input logic             neg,
                                                  input logic             rw,
                                                  input logic [F_W-1:0]   rr);
        logic [OUT_W-1:0] t;
        logic [G_W-1:0]   te;
        t  = neg ? (OUT_W'(0) - s) : s;
        te = {{F_W{t[OUT_W-1]}}, t};
        // Low G_W bits of the unsigned product equal the exact signed x unsigned product, which always fits.
        return rw ? te : te * {{OUT_W{1'b0}}, rr};
    endfunction

    logic [OUT_W-1:0] lut_tbl [0:NL];
    for (genvar k = 0; k <= NL; k++) begin : g_lut
        localparam logic [OUT_W-1:0] LV = lut_val(k);
        assign lut_tbl[k] = LV;
    end

    logic             en;
    logic             v1_q, v2_q, v3_q, v4_q;
    side_t            sd1_d, sd1_q, sd2_q, sd3_q;
    logic [XW-1:0]    xs1_d, xc1_d, xs1_q, xc1_q;
    logic [OUT_W-1:0] ts0_q, ts1_q, tc0_q, tc1_q;
    logic [FR-1:0]    fs2_q, fc2_q;
    logic [OUT_W-1:0] ss3_q, sc3_q;
    logic [G_W-1:0]   g0_q, g1_q;
    logic [1:0]       quad;
    logic [U_W-3:0]   p;
    logic [XW-1:0]    px, mpx;
    logic [KW-1:0]    ks, kc, ks_n, kc_n;

    assign en        = !v4_q || out_ready;
    assign in_ready  = en;
    assign out_valid = v4_q;
    assign g0        = g0_q;
    assign g1        = g1_q;

    always_comb begin
        quad         = u1[U_W-1 -: 2];
        p            = u1[U_W-3:0];
        px           = {1'b0, p};
        mpx          = M_X - px;
        xs1_d        = quad[0] ? mpx : px;
        xc1_d        = quad[0] ? px : mpx;
        sd1_d.neg_s  = quad[1];
        sd1_d.neg_c  = quad[1] ^ quad[0];
        sd1_d.raw    = raw;
        sd1_d.r      = r;
    end

    // The next-entry index saturates at the top; there f is always 0 so the endpoint is used as-is.
    always_comb begin
        ks   = xs1_q[XW-1:FR];
        kc   = xc1_q[XW-1:FR];
        ks_n = (ks == KW'(NL)) ? ks : ks + KW'(1);
        kc_n = (kc == KW'(NL)) ? kc : kc + KW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            v4_q  <= 1'b0;
            sd1_q <= '0;
            sd2_q <= '0;
            sd3_q <= '0;
            xs1_q <= '0;
            xc1_q <= '0;
            ts0_q <= '0;
            ts1_q <= '0;
            tc0_q <= '0;
            tc1_q <= '0;
            fs2_q <= '0;
            fc2_q <= '0;
            ss3_q <= '0;
            sc3_q <= '0;
            g0_q  <= '0;
            g1_q  <= '0;
        end else if (en) begin
            v1_q <= in_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
            v4_q <= v3_q;
            if (in_valid) begin
                xs1_q <= xs1_d;
                xc1_q <= xc1_d;
                sd1_q <= sd1_d;
            end
            if (v1_q) begin
                ts0_q <= lut_tbl[ks];
                ts1_q <= lut_tbl[ks_n];
                tc0_q <= lut_tbl[kc];
                tc1_q <= lut_tbl[kc_n];
                fs2_q <= xs1_q[FR-1:0];
                fc2_q <= xc1_q[FR-1:0];
                sd2_q <= sd1_q;
            end
            if (v2_q) begin
                ss3_q <= interp(ts0_q, ts1_q, fs2_q);
                sc3_q <= interp(tc0_q, tc1_q, fc2_q);
                sd3_q <= sd2_q;
            end
            if (v3_q) begin
                g0_q <= sign_scale(sc3_q, sd3_q.neg_c, sd3_q.raw, sd3_q.r);
                g1_q <= sign_scale(ss3_q, sd3_q.neg_s, sd3_q.raw, sd3_q.r);
            end
        end
    end
endmodule

// File: tb/tb_sino_pipe.sv
// tb_sino_pipe: drives sino_pipe and compares against a trig reference model built from $sin.
module tb_sino_pipe;
    localparam int U_W    = 16;
    localparam int LUT_AW = 8;
    localparam int OUT_W  = 18;
    localparam int F_W    = 16;
    localparam int G_W    = OUT_W + F_W;
    localparam int M      = 2 ** (U_W - 2);
    localparam int NL     = 2 ** LUT_AW;
    localparam int STEP   = M / NL;
    localparam real PI    = 3.14159265358979323846;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [U_W-1:0]        u1;
    logic [F_W-1:0]        r;
    logic                  raw;
    logic                  out_valid;
    logic                  out_ready;
    logic signed [G_W-1:0] g0;
    logic signed [G_W-1:0] g1;

    int     tests = 0;
    int     fails = 0;
    longint tbl [0:NL];

    always #5 clk = ~clk;

    sino_pipe #(.U_W(U_W), .LUT_AW(LUT_AW), .OUT_W(OUT_W), .F_W(F_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .u1(u1), .r(r), .raw(raw), .out_valid(out_valid), .out_ready(out_ready),
        .g0(g0), .g1(g1)
    );

    function automatic longint fdiv(input longint a, input longint b);
        longint qq;
        qq = a / b;
        if ((a % b != 0) && ((a < 0) != (b < 0))) qq = qq - 1;
        return qq;
    endfunction

    // Quarter-wave sine at x in [0, M], interpolated between table points.
    function automatic longint qsin(input int x);
        int k;
        int f;
        k = x / STEP;
        f = x % STEP;
        if (k >= NL) return tbl[NL];
        return tbl[k] + fdiv((tbl[k+1] - tbl[k]) * f, STEP);
    endfunction

    function automatic void model(input int u, input longint rr, input bit rw,
                                  output longint e0, output longint e1);
        int     q;
        int     p;
        longint sp, sm, c, s;
        q  = u / M;
        p  = u % M;
        sp = qsin(p);
        sm = qsin(M - p);
        case (q)
            0:       begin s = sp;  c = sm;  end
            1:       begin s = sm;  c = -sp; end
            2:       begin s = -sp; c = -sm; end
            default: begin s = -sm; c = sp;  end
        endcase
        e0 = rw ? c : c * rr;
        e1 = rw ? s : s * rr;
    endfunction

    // Sends one sample with out_ready held high and returns the first output seen.
    task automatic send_one(input logic [U_W-1:0] u, input logic [F_W-1:0] rr, input logic rw,
                            output longint o0, output longint o1, output bit got);
        got = 0;
        o0  = 0;
        o1  = 0;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        u1        = u;
        r         = rr;
        raw       = rw;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (out_valid) begin
                got = 1;
                o0  = g0;
                o1  = g1;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        tests++;
        if (out_valid !== 1'b0 || g0 !== 0 || g1 !== 0 || in_ready !== 1'b1)
            $display("FAIL reset_state: out_valid=%b g0=%0d g1=%0d in_ready=%b, want 0 0 0 1",
                     out_valid, g0, g1, in_ready);
        if (out_valid !== 1'b0 || g0 !== 0 || g1 !== 0 || in_ready !== 1'b1) fails++;
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_quadrants();
        logic [U_W-1:0] us [4];
        longint         e0 [4];
        longint         e1 [4];
        logic           want_v;
        us = '{16'h0000, 16'h4000, 16'h8000, 16'hC000};
        e0 = '{65536, 0, -65536, 0};
        e1 = '{0, 65536, 0, -65536};
        out_ready = 1'b1;
        raw       = 1'b1;
        r         = '0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            want_v = (c >= 4 && c <= 7);
            tests++;
            if (out_valid !== want_v) begin
                fails++;
                $display("FAIL quad_valid cycle %0d: got %b want %b", c, out_valid, want_v);
            end
            if (want_v) begin
                tests++;
                if (g0 !== e0[c-4] || g1 !== e1[c-4]) begin
                    fails++;
                    $display("FAIL quad_value u=%h: got %0d/%0d want %0d/%0d",
                             us[c-4], g0, g1, e0[c-4], e1[c-4]);
                end
            end
            if (c < 4) begin
                in_valid = 1'b1;
                u1       = us[c];
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_octant();
        longint o0, o1, e0, e1, e_sin;
        bit     got;
        send_one(16'h2000, '0, 1'b1, o0, o1, got);
        tests++;
        if (!got || o0 !== 46341 || o1 !== 46341) begin
            fails++;
            $display("FAIL octant_2000: got %0d/%0d (seen=%0d) want 46341/46341", o0, o1, got);
        end
        send_one(16'h2020, '0, 1'b1, o0, o1, got);
        e_sin = tbl[128] + fdiv((tbl[129] - tbl[128]) * 32, 64);
        model(32'h2020, 0, 1'b1, e0, e1);
        tests++;
        if (!got || o1 !== e_sin) begin
            fails++;
            $display("FAIL interp_sin: got %0d want %0d", o1, e_sin);
        end
        tests++;
        if (!got || o0 !== e0) begin
            fails++;
            $display("FAIL interp_cos: got %0d want %0d", o0, e0);
        end
    endtask

    task automatic test_scale();
        longint         o0, o1, e0, e1;
        bit             got;
        logic [U_W-1:0] uu;
        logic [F_W-1:0] rr;
        send_one(16'h0000, 16'h2000, 1'b0, o0, o1, got);
        tests++;
        if (!got || o0 !== 64'sd536870912 || o1 !== 0) begin
            fails++;
            $display("FAIL scale_r2000: got %0d/%0d want 536870912/0", o0, o1);
        end
        send_one(16'hC000, 16'hFFFF, 1'b0, o0, o1, got);
        tests++;
        if (!got || o0 !== 0 || o1 !== -64'sd4294901760) begin
            fails++;
            $display("FAIL scale_rmax: got %0d/%0d want 0/-4294901760", o0, o1);
        end
        for (int i = 0; i < 4; i++) begin
            uu = U_W'($urandom);
            rr = F_W'($urandom);
            send_one(uu, rr, 1'b0, o0, o1, got);
            model(int'(uu), longint'(rr), 1'b0, e0, e1);
            tests++;
            if (!got || o0 !== e0 || o1 !== e1) begin
                fails++;
                $display("FAIL scale_rand u=%h r=%h: got %0d/%0d want %0d/%0d", uu, rr, o0, o1, e0, e1);
            end
        end
    endtask

    task automatic test_back_to_back();
        longint                q0 [$];
        longint                q1 [$];
        longint                e0, e1;
        int                    sent, rcvd, extra;
        logic                  hold;
        logic signed [G_W-1:0] h0, h1;
        sent = 0;
        rcvd = 0;
        hold = 1'b0;
        h0   = '0;
        h1   = '0;
        for (int cyc = 0; cyc < 400 && rcvd < 16; cyc++) begin
            @(negedge clk);
            if (hold) begin
                tests++;
                if (out_valid !== 1'b1 || g0 !== h0 || g1 !== h1) begin
                    fails++;
                    $display("FAIL stall_hold: got v=%b %0d/%0d want v=1 %0d/%0d", out_valid, g0, g1, h0, h1);
                end
            end
            out_ready = 1'($urandom_range(0, 1));
            if (sent < 16 && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                u1       = U_W'($urandom);
                r        = F_W'($urandom);
                raw      = 1'($urandom_range(0, 1));
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                tests++;
                rcvd++;
                if (q0.size() == 0) begin
                    fails++;
                    $display("FAIL stream_extra: got %0d/%0d with nothing outstanding", g0, g1);
                end else begin
                    e0 = q0.pop_front();
                    e1 = q1.pop_front();
                    if (g0 !== e0 || g1 !== e1) begin
                        fails++;
                        $display("FAIL stream_value #%0d: got %0d/%0d want %0d/%0d", rcvd, g0, g1, e0, e1);
                    end
                end
            end
            if (in_valid && in_ready) begin
                model(int'(u1), longint'(r), raw, e0, e1);
                q0.push_back(e0);
                q1.push_back(e1);
                sent++;
            end
            hold = out_valid && !out_ready;
            h0   = g0;
            h1   = g1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        extra     = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        tests++;
        if (sent != 16 || rcvd != 16 || q0.size() != 0 || extra != 0) begin
            fails++;
            $display("FAIL stream_count: sent=%0d rcvd=%0d left=%0d extra=%0d want 16 16 0 0",
                     sent, rcvd, q0.size(), extra);
        end
    endtask

    task automatic test_async_reset();
        longint o0, o1, e0, e1;
        bit     got;
        int     stale;
        @(negedge clk);
        out_ready = 1'b0;
        raw       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            u1       = U_W'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
        tests++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL rst_preload: out_valid got %b want 1", out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || g0 !== 0 || g1 !== 0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_async: got v=%b %0d/%0d rdy=%b want 0 0/0 1", out_valid, g0, g1, in_ready);
        end
        #10 rst_n = 1'b1;
        out_ready = 1'b1;
        stale     = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        tests++;
        if (stale != 0) begin
            fails++;
            $display("FAIL rst_stale: got %0d stale outputs want 0", stale);
        end
        send_one(16'h5A5A, 16'h1234, 1'b0, o0, o1, got);
        model(32'h5A5A, 64'h1234, 1'b0, e0, e1);
        tests++;
        if (!got || o0 !== e0 || o1 !== e1) begin
            fails++;
            $display("FAIL rst_recover: got %0d/%0d want %0d/%0d", o0, o1, e0, e1);
        end
    endtask

    task automatic test_sweep();
        int     nxt_in, nxt_out;
        longint e0, e1;
        nxt_in    = 0;
        nxt_out   = 0;
        out_ready = 1'b1;
        raw       = 1'b1;
        r         = '0;
        for (int cyc = 0; cyc < 65536 + 50 && nxt_out < 65536; cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                model(nxt_out, 0, 1'b1, e0, e1);
                tests++;
                if (g0 !== e0 || g1 !== e1) begin
                    fails++;
                    $display("FAIL sweep u=%0d: got %0d/%0d want %0d/%0d", nxt_out, g0, g1, e0, e1);
                end
                tests++;
                if (g0 > 65536 || g0 < -65536 || g1 > 65536 || g1 < -65536) begin
                    fails++;
                    $display("FAIL sweep_mag u=%0d: got %0d/%0d want |g|<=65536", nxt_out, g0, g1);
                end
                nxt_out++;
            end
            if (nxt_in < 65536) begin
                in_valid = 1'b1;
                u1       = U_W'(nxt_in);
                nxt_in++;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        tests++;
        if (nxt_out != 65536) begin
            fails++;
            $display("FAIL sweep_count: got %0d outputs want 65536", nxt_out);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        u1        = '0;
        r         = '0;
        raw       = 1'b1;
        for (int k = 0; k <= NL; k++)
            tbl[k] = longint'($floor(65536.0 * $sin(PI / 2.0 * real'(k) / real'(NL)) + 0.5));
        test_reset();
        test_quadrants();
        test_octant();
        test_scale();
        test_back_to_back();
        test_async_reset();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
